mux_rr_arb: RTL and testbench
=============================

MUX_RR_ARB -- requirements
Module: mux_rr_arb

Interface
REQ-001 Parameter WIDTH, default 16, data width per channel; SHALL be legal for 1..64.
REQ-002 Parameter WAYS, default 4, number of input channels; SHALL be legal for 2..16.
REQ-003 Parameter SELW, default $clog2(WAYS), select/source index width; SHALL NOT be overridden.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 inp  input  WAYS*WIDTH  channel data, channel i at bits [i*WIDTH +: WIDTH].
REQ-007 inp_valid  input  WAYS  per-channel valid.
REQ-008 inp_ready  output  WAYS  per-channel ready; one-hot or zero.
REQ-009 mode  input  1  0 = round-robin arbitration, 1 = fixed select by line.
REQ-010 line  input  SELW  channel index used when mode=1.
REQ-011 out  output  WIDTH  registered selected data.
REQ-012 out_src  output  SELW  index of the channel that supplied out.
REQ-013 out_valid  output  1  out/out_src hold a word.
REQ-014 out_ready  input  1  downstream accepts the word.

Function
REQ-015 Block SHALL be a single registered output stage: accepted word appears on out one cycle after the accepting edge.
REQ-016 load_en SHALL be !out_valid | out_ready; inp_ready SHALL be all-zero when load_en=0.
REQ-017 Mode 0: grant SHALL go to the first channel with inp_valid=1 searching from index ptr upward, wrapping from WAYS-1 to 0.
REQ-018 Mode 1: grant SHALL go to channel line only if inp_valid[line]=1; line >= WAYS SHALL grant nothing.
REQ-019 inp_ready[g] SHALL be 1 only for the granted channel g and only when load_en=1; combinational from inputs and state, no dependence on inp data.
REQ-020 Transfer on channel g SHALL occur on an edge where inp_valid[g] & inp_ready[g]; then out <= inp[g], out_src <= g, out_valid <= 1.
REQ-021 In mode 0, ptr SHALL become (g+1) mod WAYS after each transfer; unchanged otherwise.
REQ-022 In mode 1, ptr SHALL NOT change.
REQ-023 If load_en=1, out_valid=1 and no grant, out_valid SHALL drop to 0 on the edge; out and out_src SHALL hold previous values.
REQ-024 While out_valid=1 and out_ready=0, out, out_src, out_valid SHALL hold stable.
REQ-025 Simultaneous out_ready=1 and new transfer SHALL replace the word in the same edge: throughput one word per cycle, no bubble.
REQ-026 A change of mode or line SHALL affect only arbitration of the current cycle; the held output word SHALL be unaffected.
REQ-027 With all WAYS channels continuously valid and out_ready=1 in mode 0, out_src SHALL sequence 0,1,...,WAYS-1,0,... with no channel skipped or repeated.
REQ-028 Sources with inp_valid deasserted SHALL be skipped without consuming a cycle.

Reset
REQ-029 On rst_n=0, asynchronously: out=0, out_src=0, out_valid=0, ptr=0.
REQ-030 During reset inp_ready SHALL be all-zero.
REQ-031 Reset asserted mid-stream SHALL discard any held word; no transfer SHALL be reported for the edge coinciding with reset.
REQ-032 First transfer after rst_n rises SHALL be possible on the first clock edge.

Verification
REQ-033 WAYS=4, WIDTH=16, mode 0, inp ch i = 16'h1110*i+i, all valid, out_ready=1 -> out_src 0,1,2,3,0 on consecutive cycles, out matching 0000,1111,2222,3333,0000.
REQ-034 mode 0, only ch2 and ch3 valid, ptr=3 -> grants 3,2,3,2; inp_ready never set on ch0/ch1.
REQ-035 Backpressure: word 16'hABCD held with out_ready=0 for 5 cycles while inputs change -> out stays ABCD, inp_ready=0000; out_ready=1 -> next word loaded same edge.
REQ-036 mode 1, line=1, all valid, inp ch1=16'hFFFF -> out=FFFF every cycle, out_src=1, ptr unchanged; line=0 with inp_valid[0]=0 -> out_valid falls after current word consumed.
REQ-037 rst_n pulsed low asynchronously between edges with out_valid=1 -> out=0, out_valid=0, inp_ready=0 immediately; after release, ch0 granted first.
REQ-038 WAYS=3 (non-power-of-two), mode 1, line=3 -> no grant, out_valid=0; mode 0 rotation 0,1,2,0.

Source files
------------

// File: rtl/mux_rr_arb.sv
//------------------------------------------------------------------------------
// mux_rr_arb
//   N-way data multiplexer with one registered output stage. Channel
//   selection is either round-robin (mode=0) or fixed by 'line' (mode=1).
//   A word is taken from channel g when inp_valid[g] & inp_ready[g]. It
//   appears on 'out' one cycle later, tagged with its source index in
//   'out_src'.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   inp        WAYS*WIDTH packed channel data, channel i at [i*WIDTH +: WIDTH]
//   inp_valid  per-channel valid
//   inp_ready  per-channel ready, one-hot or zero
//   mode       0 = round-robin, 1 = fixed select by 'line'
//   line       channel index used when mode=1 (values >= WAYS select nothing)
//   out        registered selected data
//   out_src    index of the channel that supplied 'out'
//   out_valid  out/out_src hold a word
//   out_ready  downstream accepts the word
//------------------------------------------------------------------------------
module mux_rr_arb #(
   parameter int WIDTH = 16,
   parameter int WAYS  = 4,
   parameter int SELW  = $clog2(WAYS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WAYS*WIDTH-1:0] inp,
   input  logic [WAYS-1:0]       inp_valid,
   output logic [WAYS-1:0]       inp_ready,
   input  logic                  mode,
   input  logic [SELW-1:0]       line,
   output logic [WIDTH-1:0]      out,
   output logic [SELW-1:0]       out_src,
   output logic                  out_valid,
   input  logic                  out_ready
);

   logic [SELW-1:0]  ptr;         // round-robin search start
   logic [SELW-1:0]  ptr_next;
   logic             load_en;     // output stage can take a new word
   logic             grant_any;
   logic [SELW-1:0]  grant_idx;
   logic [WAYS-1:0]  grant_oh;
   logic [WIDTH-1:0] grant_data;
   logic             transfer;

   assign load_en = !out_valid || out_ready;

   // Grant selection.
   // NOTE: every variable driven here gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      if (mode) begin
         // Fixed select. A line value with no matching channel grants nothing.
         for (int i = 0; i < WAYS; i++) begin
            if (!grant_any && line == SELW'(i) && inp_valid[i]) begin
               grant_any = 1'b1;
               grant_idx = SELW'(i);
            end
         end
      end else begin
         // Round-robin in two passes. The first pass covers channels ptr..WAYS-1.
         // If it finds nothing, the second pass takes the lowest valid channel.
         // That channel is necessarily below ptr, which gives the wrap to 0.
         for (int i = 0; i < WAYS; i++) begin
            if (!grant_any && inp_valid[i] && SELW'(i) >= ptr) begin
               grant_any = 1'b1;
               grant_idx = SELW'(i);
            end
         end
         for (int i = 0; i < WAYS; i++) begin
            if (!grant_any && inp_valid[i]) begin
               grant_any = 1'b1;
               grant_idx = SELW'(i);
            end
         end
      end
   end

   // One-hot form of the grant, plus the data of the granted channel.
   always_comb begin
      grant_oh   = '0;
      grant_data = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (grant_any && grant_idx == SELW'(i)) begin
            grant_oh[i] = 1'b1;
            grant_data  = inp[i*WIDTH +: WIDTH];
         end
      end
   end

   // inp_ready is forced low while reset is held, even though load_en is high then.
   assign inp_ready = (load_en && rst_n) ? grant_oh : '0;
   assign transfer  = |(inp_ready & inp_valid);
   assign ptr_next  = (grant_idx == SELW'(WAYS - 1)) ? '0 : grant_idx + SELW'(1);

   // Output stage and pointer.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples values from before the edge.
   // NOTE: the data register is reset too, so 'out' reads as zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= '0;
         out_src   <= '0;
         out_valid <= 1'b0;
         ptr       <= '0;
      end else if (load_en) begin
         if (transfer) begin
            out       <= grant_data;
            out_src   <= grant_idx;
            out_valid <= 1'b1;
            if (!mode) begin
               ptr <= ptr_next;
            end
         end else begin
            // The word was consumed or the stage was empty, and nothing
            // replaces it. out/out_src keep their last values.
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_rr_arb.sv
//------------------------------------------------------------------------------
// tb_mux_rr_arb
//   Directed self-checking bench for mux_rr_arb. Instance 'dut_a' uses the
//   default WAYS=4. Instance 'dut_b' uses WAYS=3 to cover a non-power-of-two
//   channel count. Both instances share one clock and one reset.
//------------------------------------------------------------------------------
module tb_mux_rr_arb;

   logic        clk;
   logic        rst_n;

   // dut_a: WAYS=4, WIDTH=16
   logic [63:0] a_inp;
   logic [3:0]  a_valid;
   logic [3:0]  a_rdy;
   logic        a_mode;
   logic [1:0]  a_line;
   logic [15:0] a_out;
   logic [1:0]  a_src;
   logic        a_ovalid;
   logic        a_oready;

   // dut_b: WAYS=3, WIDTH=16
   logic [47:0] b_inp;
   logic [2:0]  b_valid;
   logic [2:0]  b_rdy;
   logic        b_mode;
   logic [1:0]  b_line;
   logic [15:0] b_out;
   logic [1:0]  b_src;
   logic        b_ovalid;
   logic        b_oready;

   int checks = 0;
   int errors = 0;

   mux_rr_arb #(.WIDTH(16), .WAYS(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .inp(a_inp), .inp_valid(a_valid),
      .inp_ready(a_rdy), .mode(a_mode), .line(a_line), .out(a_out),
      .out_src(a_src), .out_valid(a_ovalid), .out_ready(a_oready)
   );

   mux_rr_arb #(.WIDTH(16), .WAYS(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .inp(b_inp), .inp_valid(b_valid),
      .inp_ready(b_rdy), .mode(b_mode), .line(b_line), .out(b_out),
      .out_src(b_src), .out_valid(b_ovalid), .out_ready(b_oready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait for the next rising edge, then settle past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] seq [4];
      int         e;

      rst_n    = 1'b0;
      a_inp    = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
      a_valid  = 4'hF;
      a_mode   = 1'b0;
      a_line   = 2'd0;
      a_oready = 1'b1;
      b_inp    = {16'h2222, 16'h1111, 16'h0000};
      b_valid  = 3'b000;
      b_mode   = 1'b0;
      b_line   = 2'd0;
      b_oready = 1'b1;

      // Reset state (one edge passes at t=5 while reset is held).
      #12;
      check("rst_out",       a_out,    16'h0);
      check("rst_out_src",   a_src,    2'd0);
      check("rst_out_valid", a_ovalid, 1'b0);
      check("rst_inp_ready", a_rdy,    4'b0000);

      // Release between edges. ch0 must be granted at once.
      rst_n = 1'b1;
      #1;
      check("first_grant_ready", a_rdy, 4'b0001);

      // Round-robin over all four channels, all valid, out_ready=1.
      for (int n = 0; n < 5; n++) begin
         tick();
         e = n % 4;
         check("rr_out_src",   a_src,    64'(e));
         check("rr_out",       a_out,    64'(16'h1111 * e));
         check("rr_out_valid", a_ovalid, 1'b1);
      end
      // ptr is now 1.

      // Drive ptr to 3 with a single ch2 transfer.
      a_valid = 4'b0100;
      #1;
      check("ptr3_ready", a_rdy, 4'b0100);
      tick();
      check("ptr3_src", a_src, 2'd2);

      // Only ch2 and ch3 valid, starting from ptr=3.
      a_valid = 4'b1100;
      seq = '{2'd3, 2'd2, 2'd3, 2'd2};
      for (int n = 0; n < 4; n++) begin
         #1;
         check("skip_ready", a_rdy, 4'b0001 << seq[n]);
         tick();
         check("skip_src", a_src, seq[n]);
         check("skip_out", a_out, 16'h1111 * seq[n]);
      end
      // ptr is now 3.

      // Backpressure. Load ABCD from ch0, then hold it for five cycles.
      a_inp[15:0] = 16'hABCD;
      a_valid     = 4'b0001;
      #1;
      check("bp_load_ready", a_rdy, 4'b0001);
      tick();
      check("bp_load_out", a_out, 16'hABCD);
      a_oready = 1'b0;
      for (int n = 0; n < 5; n++) begin
         a_inp   = {4{16'h0F0F + 16'(n * 16'h1000)}};
         a_valid = (n % 2 == 0) ? 4'hF : 4'b1010;
         #1;
         check("bp_ready_zero", a_rdy, 4'b0000);
         tick();
         check("bp_hold_out",   a_out,    16'hABCD);
         check("bp_hold_src",   a_src,    2'd0);
         check("bp_hold_valid", a_ovalid, 1'b1);
      end
      // Release: ptr=1, so ch1 replaces the word on the same edge.
      a_inp    = {16'h3333, 16'h2222, 16'h1234, 16'hABCD};
      a_valid  = 4'hF;
      a_oready = 1'b1;
      #1;
      check("bp_release_ready", a_rdy, 4'b0010);
      tick();
      check("bp_release_out", a_out, 16'h1234);
      check("bp_release_src", a_src, 2'd1);
      // ptr is now 2.

      // Fixed select, line=1.
      a_mode       = 1'b1;
      a_line       = 2'd1;
      a_inp[31:16] = 16'hFFFF;
      for (int n = 0; n < 3; n++) begin
         #1;
         check("fix_ready", a_rdy, 4'b0010);
         tick();
         check("fix_out", a_out, 16'hFFFF);
         check("fix_src", a_src, 2'd1);
      end
      // line=0 with ch0 invalid. Hold the current word one cycle, then drain.
      a_oready = 1'b0;
      a_line   = 2'd0;
      a_valid  = 4'b1110;
      #1;
      check("fix_nogrant_hold_ready", a_rdy, 4'b0000);
      tick();
      check("fix_held_valid", a_ovalid, 1'b1);
      check("fix_held_out",   a_out,    16'hFFFF);
      a_oready = 1'b1;
      #1;
      check("fix_nogrant_ready", a_rdy, 4'b0000);
      tick();
      check("drain_valid", a_ovalid, 1'b0);
      check("drain_out",   a_out,    16'hFFFF);
      check("drain_src",   a_src,    2'd1);
      // Back to round-robin. ptr must still be 2.
      a_mode  = 1'b0;
      a_valid = 4'hF;
      #1;
      check("ptr_kept_ready", a_rdy, 4'b0100);

      // Mid-stream asynchronous reset.
      tick();
      check("pre_rst_valid", a_ovalid, 1'b1);
      check("pre_rst_src",   a_src,    2'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out",   a_out,    16'h0);
      check("async_rst_valid", a_ovalid, 1'b0);
      check("async_rst_src",   a_src,    2'd0);
      check("async_rst_ready", a_rdy,    4'b0000);
      #1;
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", a_rdy, 4'b0001);
      tick();
      check("post_rst_src", a_src, 2'd0);
      check("post_rst_out", a_out, 16'hABCD);

      // WAYS=3: line=3 selects nothing.
      b_mode  = 1'b1;
      b_line  = 2'd3;
      b_valid = 3'b111;
      #1;
      check("w3_line3_ready", b_rdy, 3'b000);
      tick();
      check("w3_line3_valid", b_ovalid, 1'b0);
      // WAYS=3 round-robin wraps from 2 to 0.
      b_mode = 1'b0;
      for (int n = 0; n < 4; n++) begin
         e = n % 3;
         #1;
         check("w3_rr_ready", b_rdy, 3'b001 << e);
         tick();
         check("w3_rr_src", b_src, 64'(e));
         check("w3_rr_out", b_out, 64'(16'h1111 * e));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
